// File: rtl/dac_spi_writer.sv
// Dual-channel 12-bit SPI DAC writer: streams channel A then B as two 16-bit
// mode-0 frames, then pulses LDAC so both DAC outputs update together.
module dac_spi_writer #(
  parameter int CLK_DIV = 3,
  parameter int CS_GAP  = 4,
  parameter int LDAC_W  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] sample_a,
  input  logic [11:0] sample_b,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        busy,
  output logic        overrun,
  output logic        dac_cs_n,
  output logic        dac_sck,
  output logic        dac_sdi,
  output logic        dac_ldac_n
);

  typedef enum logic [2:0] {
    S_IDLE, S_FRAME_A, S_GAP_A, S_FRAME_B, S_GAP_B, S_LDAC
  } state_t;

  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_MAX = (CS_GAP > LDAC_W) ? CS_GAP : LDAC_W;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  state_t             state_reg;
  logic [DIV_W-1:0]   div_reg;
  logic [5:0]         ph_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [11:0]        a_reg, b_reg;
  logic               busy_reg, ready_reg, overrun_reg;
  logic               cs_n_reg, sck_reg, sdi_reg, ldac_n_reg;

  logic [5:0]  ph_inc;
  logic [3:0]  bit_sel;
  logic [15:0] frame_word;
  logic        div_last, gap_last, ldac_last;

  // A frame is 33 half-phases: 16 x (low, high) followed by one low hold phase.
  assign ph_inc     = ph_reg + 6'd1;
  assign bit_sel    = 4'd15 - ph_inc[4:1];
  assign frame_word = (state_reg == S_FRAME_B) ? {4'hB, b_reg} : {4'h3, a_reg};
  assign div_last   = (div_reg == DIV_W'(CLK_DIV - 1));
  assign gap_last   = (cnt_reg == CNT_W'(CS_GAP - 1));
  assign ldac_last  = (cnt_reg == CNT_W'(LDAC_W - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      div_reg     <= '0;
      ph_reg      <= '0;
      cnt_reg     <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      busy_reg    <= 1'b0;
      ready_reg   <= 1'b1;
      overrun_reg <= 1'b0;
      cs_n_reg    <= 1'b1;
      sck_reg     <= 1'b0;
      sdi_reg     <= 1'b0;
      ldac_n_reg  <= 1'b1;
    end else begin
      overrun_reg <= sample_valid && busy_reg;
      case (state_reg)
        S_IDLE: begin
          if (sample_valid) begin
            a_reg     <= sample_a;
            b_reg     <= sample_b;
            state_reg <= S_FRAME_A;
            busy_reg  <= 1'b1;
            ready_reg <= 1'b0;
            cs_n_reg  <= 1'b0;
            sck_reg   <= 1'b0;
            sdi_reg   <= 1'b0;  // channel-A select bit
            ph_reg    <= '0;
            div_reg   <= '0;
          end
        end
        S_FRAME_A, S_FRAME_B: begin
          if (div_last) begin
            div_reg <= '0;
            if (ph_reg == 6'd32) begin
              state_reg <= (state_reg == S_FRAME_A) ? S_GAP_A : S_GAP_B;
              cs_n_reg  <= 1'b1;
              sdi_reg   <= 1'b0;
              cnt_reg   <= '0;
            end else begin
              ph_reg <= ph_inc;
              if (ph_inc[0]) begin
                sck_reg <= 1'b1;
              end else begin
                sck_reg <= 1'b0;
                if (ph_inc != 6'd32) sdi_reg <= frame_word[bit_sel];
              end
            end
          end else begin
            div_reg <= div_reg + DIV_W'(1);
          end
        end
        S_GAP_A, S_GAP_B: begin
          if (gap_last) begin
            cnt_reg <= '0;
            if (state_reg == S_GAP_A) begin
              state_reg <= S_FRAME_B;
              cs_n_reg  <= 1'b0;
              sdi_reg   <= 1'b1;  // channel-B select bit
              ph_reg    <= '0;
              div_reg   <= '0;
            end else begin
              state_reg  <= S_LDAC;
              ldac_n_reg <= 1'b0;
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        S_LDAC: begin
          if (ldac_last) begin
            state_reg  <= S_IDLE;
            ldac_n_reg <= 1'b1;
            busy_reg   <= 1'b0;
            ready_reg  <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign sample_ready = ready_reg;
  assign busy         = busy_reg;
  assign overrun      = overrun_reg;
  assign dac_cs_n     = cs_n_reg;
  assign dac_sck      = sck_reg;
  assign dac_sdi      = sdi_reg;
  assign dac_ldac_n   = ldac_n_reg;

endmodule

// File: tb/tb_dac_spi_writer.sv
// Bench for dac_spi_writer: default-parameter and minimum-parameter instances,
// each with a transfer-level model, SPI frame decoder and frame scoreboard.
module tb_dac_spi_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst[2];
  logic        valid[2];
  logic [11:0] sa[2], sb[2];
  logic        ready[2], busy[2], ovr[2], cs_n[2], sck[2], sdi[2], ldac_n[2];
  int          exp_ldac[2];
  int          got_ldac[2];

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int CD = (gi == 0) ? 3 : 1;
    localparam int G  = (gi == 0) ? 4 : 1;
    localparam int LW = (gi == 0) ? 4 : 1;
    localparam int BT = 66 * CD + 2 * G + LW;

    dac_spi_writer #(.CLK_DIV(CD), .CS_GAP(G), .LDAC_W(LW)) u_dut (
      .clk(clk), .rst(rst[gi]), .sample_a(sa[gi]), .sample_b(sb[gi]),
      .sample_valid(valid[gi]), .sample_ready(ready[gi]), .busy(busy[gi]),
      .overrun(ovr[gi]), .dac_cs_n(cs_n[gi]), .dac_sck(sck[gi]),
      .dac_sdi(sdi[gi]), .dac_ldac_n(ldac_n[gi])
    );

    // Transfer-level model: remaining busy cycles plus the expected frame queue.
    int          rem = 0;
    logic        exp_ov = 1'b0;
    int unsigned acc_cyc = 0;
    logic [15:0] exp_q[$];

    initial begin
      exp_ldac[gi] = 0;
      forever begin
        @(posedge clk);
        if (rst[gi]) begin
          rem = 0;
          exp_ov = 1'b0;
          exp_q.delete();
        end else begin
          exp_ov = valid[gi] && (rem > 0);
          if (valid[gi] && rem == 0) begin
            rem = BT;
            acc_cyc = cyc;
            exp_q.push_back({4'h3, sa[gi]});
            exp_q.push_back({4'hB, sb[gi]});
          end else if (rem > 0) begin
            rem = rem - 1;
            if (rem == 0) exp_ldac[gi] = exp_ldac[gi] + 1;
          end
        end
      end
    end

    // Monitor: decodes SPI frames and pops the scoreboard on each chip-select fall.
    initial begin
      logic        p_cs, p_sck, p_sdi, p_ldac, aborted, have_e;
      logic [15:0] word, e;
      int          frame_len, run, nbits, ldac_run;
      p_cs = 1'b1; p_sck = 1'b0; p_sdi = 1'b0; p_ldac = 1'b1; aborted = 1'b0;
      have_e = 1'b0; word = '0; e = '0;
      frame_len = 0; run = 0; nbits = 0; ldac_run = 0;
      got_ldac[gi] = 0;
      forever begin
        @(negedge clk);
        check($sformatf("busy%0d", gi), busy[gi], rem > 0);
        check($sformatf("ready%0d", gi), ready[gi], rem == 0);
        check($sformatf("overrun%0d", gi), ovr[gi], exp_ov);
        if (cs_n[gi]) check($sformatf("idle_lines%0d", gi), {sck[gi], sdi[gi]}, 0);
        if (!ldac_n[gi]) check($sformatf("ldac_cs%0d", gi), cs_n[gi], 1);

        if (!cs_n[gi] && p_cs) begin
          frame_len = 0; run = 0; nbits = 0; word = '0; aborted = 1'b0;
          if (exp_q.size() == 0) begin
            check($sformatf("frame_unexpected%0d", gi), 1, 0);
            have_e = 1'b0;
          end else begin
            e = exp_q.pop_front();
            have_e = 1'b1;
            check($sformatf("cs_fall_offset%0d", gi), cyc - acc_cyc,
                  e[15] ? 1 + 33 * CD + G : 1);
          end
        end
        if (!cs_n[gi]) begin
          frame_len++;
          if (rst[gi]) aborted = 1'b1;
          if (sck[gi] == p_sck) begin
            run++;
          end else begin
            check($sformatf("sck_half%0d", gi), run, CD);
            if (sck[gi]) begin
              word = {word[14:0], sdi[gi]};
              nbits++;
              check($sformatf("sdi_stable%0d", gi), sdi[gi], p_sdi);
            end
            run = 1;
          end
        end
        if (cs_n[gi] && !p_cs && !aborted) begin
          check($sformatf("hold_len%0d", gi), run, CD);
          check($sformatf("frame_len%0d", gi), frame_len, 33 * CD);
          check($sformatf("frame_bits%0d", gi), nbits, 16);
          if (have_e) check($sformatf("frame_word%0d", gi), word, e);
        end

        if (!ldac_n[gi] && p_ldac) begin
          got_ldac[gi]++;
          ldac_run = 0;
          check($sformatf("ldac_offset%0d", gi), cyc - acc_cyc, 1 + 66 * CD + 2 * G);
        end
        if (!ldac_n[gi]) ldac_run++;
        if (ldac_n[gi] && !p_ldac) check($sformatf("ldac_width%0d", gi), ldac_run, LW);

        p_cs = cs_n[gi]; p_sck = sck[gi]; p_sdi = sdi[gi]; p_ldac = ldac_n[gi];
      end
    end
  end

  // Caller is aligned just after a posedge; the strobe is sampled on the next one.
  task automatic pulse(input int k, input logic [11:0] a, input logic [11:0] b);
    sa[k] = a; sb[k] = b; valid[k] = 1'b1;
    @(posedge clk);
    #1 valid[k] = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic seq0();
    pulse(0, 12'hABC, 12'h123);
    wait_cycles(260);
    // Overrun: strobes 50 cycles apart, then one just as busy falls.
    pulse(0, 12'($urandom), 12'($urandom));
    wait_cycles(49);
    pulse(0, 12'($urandom), 12'($urandom));
    check("overrun_pulse", ovr[0], 1);
    wait_cycles(160);
    pulse(0, 12'($urandom), 12'($urandom));
    check("accept_at_211", busy[0], 1);
    check("no_overrun_211", ovr[0], 0);
    wait_cycles(260);
    // Reset during FRAME_A aborts; strobe two cycles later starts fresh.
    pulse(0, 12'($urandom), 12'($urandom));
    wait_cycles(38);
    rst[0] = 1'b1;
    @(posedge clk);
    #1 rst[0] = 1'b0;
    check("abort_cs_n", cs_n[0], 1);
    check("abort_ldac_n", ldac_n[0], 1);
    wait_cycles(1);
    pulse(0, 12'($urandom), 12'($urandom));
    wait_cycles(260);
    for (int i = 0; i < 10; i++) begin
      pulse(0, 12'($urandom), 12'($urandom));
      wait_cycles(1999);
    end
    for (int i = 0; i < 20; i++) begin
      pulse(0, 12'($urandom), 12'($urandom));
      wait_cycles($urandom_range(20, 400));
    end
    wait_cycles(300);
  endtask

  task automatic seq1();
    pulse(1, 12'hFFF, 12'h000);
    wait_cycles(80);
    for (int i = 0; i < 40; i++) begin
      pulse(1, 12'($urandom), 12'($urandom));
      wait_cycles($urandom_range(1, 120));
    end
    wait_cycles(100);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; valid[k] = 1'b1; sa[k] = 12'h5A5; sb[k] = 12'hA5A;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b0; valid[k] = 1'b0;
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst_cs_n%0d", k), cs_n[k], 1);
      check($sformatf("rst_sck_sdi%0d", k), {sck[k], sdi[k]}, 0);
      check($sformatf("rst_ldac_n%0d", k), ldac_n[k], 1);
      check($sformatf("rst_busy_ready_ovr%0d", k), {busy[k], ready[k], ovr[k]}, 3'b010);
    end
    @(posedge clk);
    #1;
    fork
      seq0();
      seq1();
    join
    check("frames_left0", g_inst[0].exp_q.size(), 0);
    check("frames_left1", g_inst[1].exp_q.size(), 0);
    check("ldac_count0", got_ldac[0], exp_ldac[0]);
    check("ldac_count1", got_ldac[1], exp_ldac[1]);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    repeat (80000) @(posedge clk);
    total++;
    bad++;
    $display("FAIL watchdog: stimulus still running at cycle %0d", cyc);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
